// File: rtl/lfsr_seq_checker_if.sv
// Serial bit stream and checker status bundle between a bit source and lfsr_seq_checker.
interface lfsr_seq_checker_if;
    logic        bit_valid;
    logic        bit_in;
    logic        clear_cnt;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;

    modport master (output bit_valid, bit_in, clear_cnt,
                    input  locked, err_pulse, err_count);
    modport slave  (input  bit_valid, bit_in, clear_cnt,
                    output locked, err_pulse, err_count);
endinterface

// File: rtl/lfsr_seq_checker.sv
// Self-synchronising checker for the 13-bit Fibonacci LFSR x^13+x^4+x^3+x^1 stream.
// Define LFSR_CHK_ERRCNT_EN to build the saturating mismatch counter and clear_cnt.
module lfsr_seq_checker #(
    parameter int unsigned LOCK_THRESH = 16,
    parameter int unsigned LOSS_THRESH = 4
) (
    input  logic              clock,
    input  logic              reset,
    lfsr_seq_checker_if.slave chk
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_T = 8'(LOCK_THRESH);
    localparam logic [3:0] LOSS_T = 4'(LOSS_THRESH);

    state_t      state_q, state_d;
    logic [12:0] s_q, s_d;
    logic [3:0]  fill_cnt_q, fill_cnt_d;
    logic [7:0]  match_cnt_q, match_cnt_d;
    logic [3:0]  miss_cnt_q, miss_cnt_d;
    logic        locked_q, locked_d;
    logic        err_pulse_q, err_pulse_d;
    logic        predicted;
    logic        match;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= FILL;
            s_q         <= 13'h0000;
            fill_cnt_q  <= 4'd0;
            match_cnt_q <= 8'd0;
            miss_cnt_q  <= 4'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            fill_cnt_q  <= fill_cnt_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    // Once locked the register free-runs on its own prediction, so a corrupted bit never enters it.
    always_comb begin
        predicted   = s_q[12] ^ s_q[3] ^ s_q[2] ^ s_q[0];
        match       = (chk.bit_in == predicted);
        state_d     = state_q;
        s_d         = s_q;
        fill_cnt_d  = fill_cnt_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_pulse_d = 1'b0;
        if (chk.bit_valid) begin
            unique case (state_q)
                FILL: begin
                    s_d = {s_q[11:0], chk.bit_in};
                    if (fill_cnt_q == 4'd12) begin
                        fill_cnt_d = 4'd0;
                        if (s_d != 13'h0000) begin
                            state_d     = SYNC;
                            match_cnt_d = 8'd0;
                        end
                    end else begin
                        fill_cnt_d = fill_cnt_q + 4'd1;
                    end
                end
                SYNC: begin
                    s_d = {s_q[11:0], chk.bit_in};
                    if (match) begin
                        match_cnt_d = match_cnt_q + 8'd1;
                        if (match_cnt_d == LOCK_T) begin
                            state_d     = LOCK;
                            match_cnt_d = 8'd0;
                            miss_cnt_d  = 4'd0;
                        end
                    end else begin
                        match_cnt_d = 8'd0;
                    end
                end
                LOCK: begin
                    s_d = {s_q[11:0], predicted};
                    if (match) begin
                        miss_cnt_d = 4'd0;
                    end else begin
                        err_pulse_d = 1'b1;
                        miss_cnt_d  = miss_cnt_q + 4'd1;
                        if (miss_cnt_d == LOSS_T) begin
                            state_d    = FILL;
                            fill_cnt_d = 4'd0;
                            miss_cnt_d = 4'd0;
                        end
                    end
                end
                default: begin
                    state_d    = FILL;
                    fill_cnt_d = 4'd0;
                end
            endcase
        end
        locked_d = (state_d == LOCK);
    end

    assign chk.locked    = locked_q;
    assign chk.err_pulse = err_pulse_q;

`ifdef LFSR_CHK_ERRCNT_EN
    logic [15:0] err_count_q, err_count_d;

    // Clear has priority over a coincident mismatch; the count sticks at all-ones.
    always_comb begin
        err_count_d = err_count_q;
        if (chk.clear_cnt) begin
            err_count_d = 16'h0000;
        end else if (err_pulse_d && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_count_q <= 16'h0000;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign chk.err_count = err_count_q;
`else
    assign chk.err_count = 16'h0000;
`endif

endmodule
